// File: rtl/circle_ctrl_pkg.sv
// Shared types and default widths for the circle controller and its datapath.
package circle_ctrl_pkg;

    localparam int unsigned OFFSET_X_DW_DEF = 9;
    localparam int unsigned OFFSET_Y_DW_DEF = 8;
    localparam int unsigned CRIT_DW_DEF     = 9;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StInit,
        StCheck,
        StPlot,
        StUpdate,
        StDone
    } circle_state_e;

endpackage

// File: rtl/circle_ctrl.sv
// Control FSM for clearing the screen and drawing one Bresenham circle, eight octants per step.
module circle_ctrl
    import circle_ctrl_pkg::*;
#(
    parameter int unsigned OFFSET_X_DW = OFFSET_X_DW_DEF,
    parameter int unsigned OFFSET_Y_DW = OFFSET_Y_DW_DEF,
    parameter int unsigned CRIT_DW     = CRIT_DW_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   done,
    output logic                   fill_start,
    input  logic                   fill_done,
    output logic                   draw_circle,
    output logic [2:0]             octant_sel,
    output logic                   load_x,
    output logic                   load_y,
    output logic                   load_crit,
    output logic                   inc_y,
    output logic                   dec_x,
    output logic                   calc_crit,
    input  logic [OFFSET_X_DW-1:0] offset_x,
    input  logic [OFFSET_Y_DW-1:0] offset_y,
    input  logic [CRIT_DW-1:0]     crit
);

    circle_state_e state_q, state_d;
    logic [2:0]    oct_q, oct_d;

    logic signed [OFFSET_X_DW-1:0] x_s;
    logic signed [OFFSET_X_DW-1:0] y_ext;
    logic                          y_le_x;
    logic                          crit_pos;

    assign x_s    = offset_x;
    assign y_ext  = OFFSET_X_DW'($signed(offset_y));
    assign y_le_x = (y_ext <= x_s);
    // Strictly positive: sign bit clear and not all zeros.
    assign crit_pos = ~crit[CRIT_DW-1] & (|crit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            oct_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        oct_d       = oct_q;
        done        = 1'b0;
        fill_start  = 1'b0;
        draw_circle = 1'b0;
        octant_sel  = 3'd0;
        load_x      = 1'b0;
        load_y      = 1'b0;
        load_crit   = 1'b0;
        inc_y       = 1'b0;
        dec_x       = 1'b0;
        calc_crit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                fill_start = 1'b1;
                if (fill_done) state_d = StInit;
            end
            StInit: begin
                load_x    = 1'b1;
                load_y    = 1'b1;
                load_crit = 1'b1;
                state_d   = StCheck;
            end
            StCheck: begin
                if (y_le_x) begin
                    oct_d   = 3'd0;
                    state_d = StPlot;
                end else begin
                    state_d = StDone;
                end
            end
            StPlot: begin
                draw_circle = 1'b1;
                octant_sel  = oct_q;
                oct_d       = oct_q + 3'd1;
                if (oct_q == 3'd7) state_d = StUpdate;
            end
            StUpdate: begin
                inc_y     = 1'b1;
                calc_crit = 1'b1;
                dec_x     = crit_pos;
                state_d   = StCheck;
            end
            StDone: begin
                done = 1'b1;
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_circle_ctrl.sv
// Self-checking bench for circle_ctrl: datapath model, midpoint-circle reference, directed + random runs.
module tb_circle_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       done;
    logic       fill_start;
    logic       fill_done;
    logic       draw_circle;
    logic [2:0] octant_sel;
    logic       load_x, load_y, load_crit;
    logic       inc_y, dec_x, calc_crit;

    logic signed [8:0] dp_x    = '0;
    logic signed [7:0] dp_y    = '0;
    logic signed [8:0] dp_crit = '0;
    int                radius  = 0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    circle_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .done       (done),
        .fill_start (fill_start),
        .fill_done  (fill_done),
        .draw_circle(draw_circle),
        .octant_sel (octant_sel),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_crit  (load_crit),
        .inc_y      (inc_y),
        .dec_x      (dec_x),
        .calc_crit  (calc_crit),
        .offset_x   (dp_x),
        .offset_y   (dp_y),
        .crit       (dp_crit)
    );

    // {done, fill_start, draw, oct[2:0], load_x, load_y, load_crit, inc_y, dec_x, calc_crit}
    logic [11:0] act;
    assign act = {done, fill_start, draw_circle, octant_sel, load_x, load_y, load_crit,
                  inc_y, dec_x, calc_crit};

    localparam logic [11:0] VIdle  = 12'h000;
    localparam logic [11:0] VClear = 12'h400;
    localparam logic [11:0] VInit  = 12'h038;
    localparam logic [11:0] VDone  = 12'h800;

    // Behavioural datapath driven by the controller strobes.
    always @(posedge clk) begin
        int yn, xn, c;
        yn = int'(dp_y) + 1;
        xn = int'(dp_x) - (dec_x ? 1 : 0);
        c  = int'(dp_crit) + (dec_x ? 2 * (yn - xn) : 2 * yn) + 1;
        if (load_x)    dp_x <= 9'(radius);
        if (load_y)    dp_y <= '0;
        if (load_crit) dp_crit <= 9'(1 - radius);
        if (inc_y)     dp_y <= 8'(yn);
        if (dec_x)     dp_x <= 9'(xn);
        if (calc_crit) dp_crit <= 9'(c);
    end

    typedef struct {
        logic        st;
        logic        fd;
        logic [11:0] exp;
    } step_t;

    typedef struct {
        int          r;
        int          clear_cycles;
        int          hold;
        int          exp_plots;
        logic [63:0] exp_dec;
    } vec_t;

    step_t script[$];
    bit    ref_dec[$];
    int    ref_crit[$];
    int    obs_crit[$];

    task automatic check(string nm, logic [11:0] a, logic [11:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %03h expected %03h", nm, a, e);
        end
    endtask

    task automatic check_int(string nm, longint a, longint e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Midpoint circle: one entry per iteration while y <= x.
    task automatic ref_model(int r);
        int x, y, c;
        bit d;
        ref_dec.delete();
        ref_crit.delete();
        x = r;
        y = 0;
        c = 1 - r;
        while (y <= x) begin
            d = (c > 0);
            ref_dec.push_back(d);
            ref_crit.push_back(c);
            y++;
            if (d) x--;
            c = d ? c + 2 * (y - x) + 1 : c + 2 * y + 1;
        end
    endtask

    task automatic push(logic st, logic fd, logic [11:0] e);
        step_t s;
        s.st  = st;
        s.fd  = fd;
        s.exp = e;
        script.push_back(s);
    endtask

    task automatic run_circle(int r, int clear_cycles, int hold, bit noise,
                              output int plots, output logic [63:0] decmask);
        int upd;
        logic ns, nf;
        ref_model(r);
        radius = r;
        script.delete();
        obs_crit.delete();
        push(1'b1, 1'b0, VIdle);
        for (int i = 0; i < clear_cycles; i++) begin
            ns = noise ? 1'($urandom) : 1'b1;
            push(ns, (i == clear_cycles - 1), VClear);
        end
        ns = noise ? 1'($urandom) : 1'b1;
        nf = noise ? 1'($urandom) : 1'b0;
        push(ns, nf, VInit);
        foreach (ref_dec[k]) begin
            ns = noise ? 1'($urandom) : 1'b1;
            nf = noise ? 1'($urandom) : 1'b0;
            push(ns, nf, VIdle);
            for (int o = 0; o < 8; o++) begin
                ns = noise ? 1'($urandom) : 1'b1;
                nf = noise ? 1'($urandom) : 1'b0;
                push(ns, nf, 12'h200 | (12'(o) << 6));
            end
            ns = noise ? 1'($urandom) : 1'b1;
            nf = noise ? 1'($urandom) : 1'b0;
            push(ns, nf, 12'h005 | (12'(ref_dec[k]) << 1));
        end
        ns = noise ? 1'($urandom) : 1'b1;
        nf = noise ? 1'($urandom) : 1'b0;
        push(ns, nf, VIdle);
        for (int i = 0; i < hold; i++) begin
            nf = noise ? 1'($urandom) : 1'b0;
            push(1'b1, nf, VDone);
        end
        nf = noise ? 1'($urandom) : 1'b0;
        push(1'b0, nf, VDone);
        nf = noise ? 1'($urandom) : 1'b0;
        push(1'b0, nf, VIdle);

        plots   = 0;
        decmask = '0;
        upd     = 0;
        foreach (script[i]) begin
            @(negedge clk);
            check($sformatf("r%0d_step%0d", r, i), act, script[i].exp);
            if (draw_circle) plots++;
            if (calc_crit) begin
                if (dec_x && upd < 64) decmask[upd] = 1'b1;
                obs_crit.push_back(int'(dp_crit));
                upd++;
            end
            start     = script[i].st;
            fill_done = script[i].fd;
        end
        check_int($sformatf("r%0d_updates", r), obs_crit.size(), ref_crit.size());
        foreach (obs_crit[k]) begin
            if (k < ref_crit.size())
                check_int($sformatf("r%0d_crit%0d", r, k), obs_crit[k], ref_crit[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        start     = 1'b0;
        fill_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // sel 0: mid-CLEAR, 1: PLOT with octant 5, 2: UPDATE.
    task automatic reset_mid(int sel, string nm);
        bit hit;
        radius = 3;
        do_reset();
        start = 1'b1;
        hit   = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            case (sel)
                0:       hit = fill_start;
                1:       hit = draw_circle && (octant_sel == 3'd5);
                default: hit = calc_crit;
            endcase
            if (!hit) fill_done = fill_start;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s_reach: target state not seen within 200 cycles", nm);
        end
        resetn    = 1'b0;
        fill_done = 1'b1;
        @(negedge clk);
        check({nm, "_after_reset"}, act, VIdle);
        fill_done = 1'b0;
        @(negedge clk);
        check({nm, "_held_reset"}, act, VIdle);
        resetn = 1'b1;
        @(negedge clk);
        check({nm, "_restart_clear"}, act, VClear);
        fill_done = 1'b1;
        @(negedge clk);
        check({nm, "_restart_init"}, act, VInit);
        fill_done = 1'b0;
        do_reset();
    endtask

    vec_t tbl[4];

    initial begin
        int          plots;
        logic [63:0] dm;

        tbl[0] = '{r: 0, clear_cycles: 4,    hold: 2,  exp_plots: 8,  exp_dec: 64'b1};
        tbl[1] = '{r: 1, clear_cycles: 2,    hold: 2,  exp_plots: 16, exp_dec: 64'b10};
        tbl[2] = '{r: 5, clear_cycles: 3,    hold: 50, exp_plots: 32, exp_dec: 64'b1100};
        tbl[3] = '{r: 2, clear_cycles: 1001, hold: 1,  exp_plots: 16, exp_dec: 64'b10};

        resetn    = 1'b0;
        start     = 1'b1;
        fill_done = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", act, VIdle);
        resetn    = 1'b1;
        start     = 1'b0;
        fill_done = 1'b0;
        @(negedge clk);
        check("idle_no_start", act, VIdle);

        for (int i = 0; i < 4; i++) begin
            run_circle(tbl[i].r, tbl[i].clear_cycles, tbl[i].hold, 1'b0, plots, dm);
            check_int($sformatf("tbl%0d_plots", i), plots, tbl[i].exp_plots);
            check_int($sformatf("tbl%0d_decmask", i), longint'(dm), longint'(tbl[i].exp_dec));
            if (tbl[i].r == 5) begin
                int exp_c[4] = '{-4, -1, 4, 3};
                for (int k = 0; k < 4; k++) begin
                    if (k < obs_crit.size())
                        check_int($sformatf("r5_spec_crit%0d", k), obs_crit[k], exp_c[k]);
                end
            end
        end

        reset_mid(0, "rst_clear");
        reset_mid(1, "rst_plot5");
        reset_mid(2, "rst_update");

        for (int n = 0; n < 8; n++) begin
            run_circle(int'($urandom_range(0, 40)), int'($urandom_range(1, 6)),
                       int'($urandom_range(0, 5)), 1'b1, plots, dm);
            check_int($sformatf("rand%0d_plots", n), plots, 8 * ref_dec.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circle_ctrl.md
CIRCLE_CTRL -- requirements
Module: circle_ctrl

Interface
REQ-001 Parameters SHALL be: OFFSET_X_DW, default 9, width of offset_x; OFFSET_Y_DW, default 8, width of offset_y; CRIT_DW, default 9, width of crit.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  level request to clear the screen and draw one circle.
REQ-005 done  output  1  high while the circle is complete and start is still held.
REQ-006 fill_start  output  1  screen-clear request to the datapath fill engine.
REQ-007 fill_done  input  1  fill engine finished.
REQ-008 draw_circle  output  1  selects the circle pixel path (1) or the fill path (0).
REQ-009 octant_sel  output  3  unsigned octant index, 0..7.
REQ-010 load_x, load_y, load_crit  output  1 each  initialise offset_x=radius, offset_y=0 and crit=1-radius.
REQ-011 inc_y, dec_x, calc_crit  output  1 each  Bresenham step controls.
REQ-012 offset_x  input  OFFSET_X_DW  signed current x offset.
REQ-013 offset_y  input  OFFSET_Y_DW  signed current y offset.
REQ-014 crit  input  CRIT_DW  signed decision variable.

Function
REQ-015 States SHALL be IDLE, CLEAR, INIT, CHECK, PLOT, UPDATE and DONE, plus a 3-bit octant counter oct_cnt.
REQ-016 IDLE: all outputs SHALL be 0; start=1 SHALL move to CLEAR on the next edge.
REQ-017 CLEAR: fill_start SHALL be 1 and draw_circle 0; the FSM SHALL stay in CLEAR until fill_done=1 is sampled, then move to INIT.
REQ-018 INIT: load_x, load_y and load_crit SHALL be 1 for exactly one cycle, then the FSM SHALL move to CHECK.
REQ-019 CHECK: the FSM SHALL compare offset_y (sign-extended to OFFSET_X_DW) against offset_x as signed values; if offset_y <= offset_x it SHALL clear oct_cnt and move to PLOT, otherwise it SHALL move to DONE.
REQ-020 PLOT: draw_circle SHALL be 1 and octant_sel SHALL equal oct_cnt; oct_cnt SHALL increment every cycle; after the oct_cnt=7 cycle the FSM SHALL move to UPDATE, so PLOT lasts exactly 8 cycles per iteration.
REQ-021 UPDATE: inc_y and calc_crit SHALL be 1 for one cycle; dec_x SHALL be 1 in that same cycle iff crit > 0 (signed); the FSM SHALL then return to CHECK.
REQ-022 Each iteration SHALL be exactly 10 cycles (CHECK + 8 PLOT + UPDATE).
REQ-023 DONE: done SHALL be 1 and all other outputs 0; the FSM SHALL stay in DONE while start=1 and move to IDLE on start=0.
REQ-024 Changes on start outside IDLE and DONE SHALL be ignored; no abort path exists other than reset.
REQ-025 A fill_done assertion outside CLEAR SHALL be ignored.
REQ-026 Every control output SHALL be a pure decode of the registered state and oct_cnt, plus the crit input for dec_x only.

Reset
REQ-027 When resetn=0 is sampled, the state SHALL be IDLE and oct_cnt 0 on that edge, and all outputs SHALL be 0.
REQ-028 Reset asserted mid-CLEAR, mid-PLOT or mid-UPDATE SHALL abandon the operation; a later start SHALL restart from CLEAR.

Structure
REQ-029 A shared package SHALL hold the state enum and the default widths (OFFSET_X_DW, OFFSET_Y_DW, CRIT_DW); the datapath and circle_ctrl SHALL both import it.
REQ-030 circle_ctrl SHALL be a single module with no sub-modules, instantiated alongside the datapath by the task top.

Verification
REQ-031 Radius 0, fill_done pulsed 3 cycles after CLEAR entry -> exactly 8 PLOT cycles with octant_sel 0..7, dec_x=1 once, then done=1.
REQ-032 Radius 1 -> 16 PLOT cycles (2 iterations), dec_x=1 only in the second UPDATE, then DONE.
REQ-033 Radius 5 (initial crit=-4) -> 4 iterations, 32 PLOT cycles, dec_x=1 in UPDATEs 3 and 4 only, crit sequence -4,-1,4,3.
REQ-034 start held for 50 cycles after done -> done stays 1; start=0 -> IDLE next edge; a new start -> fill_start=1 again.
REQ-035 resetn=0 during PLOT with octant_sel=5 -> all outputs 0 after that edge; start reasserted -> full sequence restarts at CLEAR.
REQ-036 fill_done held 0 for 1000 cycles in CLEAR -> fill_start stays 1 and no load/plot strobes occur.
